// File: rtl/i2s_pkg.sv
// i2s_pkg: shared I2S slot polarities and frame/counter sizing helpers.
package i2s_pkg;
  localparam logic LRCK_LEFT = 1'b0;
  localparam logic LRCK_RIGHT = 1'b1;
  function automatic int frame_len(input int pdata_width);
    return 2 * pdata_width;
  endfunction
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/i2s_tx_if.sv
// i2s_tx_if: parallel stereo word handshake between a DSP source and the I2S transmitter.
interface i2s_tx_if #(parameter int PDATA_WIDTH = 32);
  logic [PDATA_WIDTH-1:0] pldata_in;
  logic [PDATA_WIDTH-1:0] prdata_in;
  logic pvalid_in;
  logic pready_out;
  modport master(output pldata_in, prdata_in, pvalid_in, input pready_out);
  modport slave(input pldata_in, prdata_in, pvalid_in, output pready_out);
endinterface

// File: rtl/i2s_clkgen.sv
// i2s_clkgen: SCLK divider and frame bit counter producing SCLK, LRCK and frame strobes.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int SCLK_DIV    = 4,
  parameter int PDATA_WIDTH = 32
) (
  input  logic clk_in,
  input  logic arst_in,
  output logic sclk_out,
  output logic lrck_out,
  output logic fall_out,
  output logic frame_start_out
);
  localparam int FRAME = frame_len(PDATA_WIDTH);
  localparam int DW = clog2(SCLK_DIV);
  localparam int BW = clog2(FRAME);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(SCLK_DIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME - 1);
  localparam logic [BW-1:0] LR_LO = BW'(PDATA_WIDTH - 1);
  localparam logic [BW-1:0] LR_HI = BW'(FRAME - 2);
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic sclk_q, sclk_d, lrck_q, lrck_d;
  // LRCK is decoded from the next bit count so it leads each channel MSB by one SCLK
  always_comb begin
    fall_out = div_cnt_q == DIV_LAST;
    frame_start_out = fall_out && bit_cnt_q == BIT_LAST;
    div_cnt_d = fall_out ? '0 : div_cnt_q + 1'b1;
    bit_cnt_d = !fall_out ? bit_cnt_q : (bit_cnt_q == BIT_LAST ? '0 : bit_cnt_q + 1'b1);
    sclk_d = div_cnt_d >= DIV_HALF;
    lrck_d = (bit_cnt_d >= LR_LO && bit_cnt_d <= LR_HI) ? LRCK_RIGHT : LRCK_LEFT;
  end
  always_ff @(posedge clk_in or posedge arst_in)
    if (arst_in) begin
      div_cnt_q <= '0;
      bit_cnt_q <= BIT_LAST;
      sclk_q <= 1'b0;
      lrck_q <= LRCK_LEFT;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q <= sclk_d;
      lrck_q <= lrck_d;
    end
  assign sclk_out = sclk_q;
  assign lrck_out = lrck_q;
endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: I2S master transmitter with a one-pair holding buffer and underrun flag.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int PDATA_WIDTH = 32,
  parameter int SCLK_DIV    = 4
) (
  input  logic      clk_in,
  input  logic      arst_in,
  i2s_tx_if.slave   pif,
  output logic      sclk_out,
  output logic      lrck_out,
  output logic      sdata_out,
  output logic      underrun_out
);
  localparam int FRAME = frame_len(PDATA_WIDTH);
  logic fall, frame_start, accept;
  logic hold_full_q, hold_full_d;
  logic [PDATA_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [FRAME-1:0] shift_q, shift_d;
  logic sdata_q, sdata_d, underrun_q, underrun_d, pready_q, pready_d;
  i2s_clkgen #(.SCLK_DIV(SCLK_DIV), .PDATA_WIDTH(PDATA_WIDTH)) u_clkgen (
    .clk_in(clk_in),
    .arst_in(arst_in),
    .sclk_out(sclk_out),
    .lrck_out(lrck_out),
    .fall_out(fall),
    .frame_start_out(frame_start)
  );
  // accept only happens with hold empty, so a coincident frame start loads the old (empty) hold
  always_comb begin
    accept = pif.pvalid_in && pready_q;
    hold_full_d = accept || (hold_full_q && !frame_start);
    hold_l_d = accept ? pif.pldata_in : hold_l_q;
    hold_r_d = accept ? pif.prdata_in : hold_r_q;
    shift_d = frame_start ? (hold_full_q ? {hold_l_q, hold_r_q} : '0) : (fall ? shift_q << 1 : shift_q);
    sdata_d = shift_d[FRAME-1];
    underrun_d = frame_start && !hold_full_q;
    pready_d = !hold_full_d;
  end
  always_ff @(posedge clk_in or posedge arst_in)
    if (arst_in) begin
      hold_full_q <= 1'b0;
      hold_l_q <= '0;
      hold_r_q <= '0;
      shift_q <= '0;
      sdata_q <= 1'b0;
      underrun_q <= 1'b0;
      pready_q <= 1'b1;
    end else begin
      hold_full_q <= hold_full_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      shift_q <= shift_d;
      sdata_q <= sdata_d;
      underrun_q <= underrun_d;
      pready_q <= pready_d;
    end
  assign sdata_out = sdata_q;
  assign underrun_out = underrun_q;
  assign pif.pready_out = pready_q;
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: cycle-level model of the I2S frame timing plus a behavioural loopback receiver.
module tb_i2s_tx;
  localparam int W = 8, DIV = 4, FL = 2 * W, FC = FL * DIV;
  logic clk = 0, rst = 0;
  logic sclk, lrck, sdata, under;
  int pass_cnt = 0, total = 0;
  i2s_tx_if #(.PDATA_WIDTH(W)) pif();
  i2s_tx #(.PDATA_WIDTH(W), .SCLK_DIV(DIV)) dut (
    .clk_in(clk),
    .arst_in(rst),
    .pif(pif),
    .sclk_out(sclk),
    .lrck_out(lrck),
    .sdata_out(sdata),
    .underrun_out(under)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: n = posedges since reset release; frame k starts at edge DIV*(1+FL*k)
  int n = 0;
  bit m_full = 0, m_under = 0, m_acc = 0;
  logic [W-1:0] m_l = '0, m_r = '0;
  logic [FL-1:0] cur = '0;
  logic [FL:0] exp_q[$];
  always @(posedge clk or posedge rst) begin
    bit fs;
    if (rst) begin
      n = 0; m_full = 0; m_under = 0; m_acc = 0; cur = '0;
      exp_q.delete();
    end else begin
      n++;
      fs = (n % DIV == 0) && ((n / DIV - 1) % FL == 0);
      m_acc = pif.pvalid_in && !m_full;
      m_under = 0;
      if (fs) begin
        m_under = !m_full;
        cur = m_full ? {m_l, m_r} : '0;
        m_full = 0;
        exp_q.push_back({m_under, cur});
      end
      if (m_acc) begin
        m_full = 1; m_l = pif.pldata_in; m_r = pif.prdata_in;
      end
    end
  end

  function automatic int cur_bit();
    return (FL - 1 + n / DIV) % FL;
  endfunction

  always @(negedge clk) begin
    int b;
    b = cur_bit();
    chk("sclk", sclk, (n % DIV) >= DIV / 2);
    chk("lrck", lrck, b >= W - 1 && b <= FL - 2);
    chk("sdata", sdata, cur[FL-1-b]);
    chk("underrun", under, m_under);
    chk("pready", pif.pready_out, !m_full);
  end

  // Receiver: sample on SCLK rise; an LRCK change marks the LSB of the previous slot
  logic [W-1:0] rx_sr = '0, rx_l = '0;
  logic rx_prev = 0;
  logic [FL-1:0] last_rx = '0;
  int rx_frames = 0, rx_data_frames = 0;
  always @(posedge sclk or posedge rst) begin
    logic [FL:0] e;
    if (rst) begin
      rx_sr = '0; rx_prev = 0;
    end else begin
      rx_sr = {rx_sr[W-2:0], sdata};
      if (lrck != rx_prev) begin
        if (lrck) rx_l = rx_sr;
        else if (exp_q.size() == 0) chk("rx_frame_expected", 0, 1);
        else begin
          e = exp_q.pop_front();
          last_rx = {rx_l, rx_sr};
          chk("loopback", last_rx, e[FL-1:0]);
          rx_frames++;
          if (!e[FL]) rx_data_frames++;
        end
      end
      rx_prev = lrck;
    end
  end

  task automatic send(input logic [W-1:0] l, input logic [W-1:0] r);
    bit ok;
    ok = 0;
    pif.pvalid_in = 1; pif.pldata_in = l; pif.prdata_in = r;
    for (int i = 0; i < 4 * FC && !ok; i++) begin
      @(negedge clk);
      ok = m_acc;
    end
    chk("send_accept", ok, 1);
    pif.pvalid_in = 0;
  endtask

  initial begin
    int t0, t1, sent, base, cnt;
    bit seen;
    pif.pvalid_in = 0; pif.pldata_in = '0; pif.prdata_in = '0;
    #1 rst = 1;
    @(negedge clk); @(negedge clk);
    chk("rst_sclk", sclk, 0); chk("rst_lrck", lrck, 0); chk("rst_sdata", sdata, 0);
    chk("rst_underrun", under, 0); chk("rst_pready", pif.pready_out, 1);
    rst = 0;
    // basic frame: accepted before the first frame start, so no underrun
    send(8'hA5, 8'h3C);
    repeat (FC + 8) @(negedge clk);
    chk("basic_frame", last_rx, 16'hA53C);
    chk("basic_frames_rx", rx_frames, 1);
    // underrun spacing
    t0 = -1; t1 = -1;
    for (int i = 0; i < 3 * FC && t1 < 0; i++) begin
      @(negedge clk);
      if (under) begin
        if (t0 < 0) t0 = i; else t1 = i;
      end
    end
    chk("underrun_period", t1 - t0, FC);
    // accept coinciding with a frame start while hold is empty
    for (int i = 0; i < 2 * FC && !(((n + 1) % DIV == 0) && (((n + 1) / DIV - 1) % FL == 0)); i++)
      @(negedge clk);
    pif.pvalid_in = 1; pif.pldata_in = 8'h5A; pif.prdata_in = 8'hC3;
    @(negedge clk);
    pif.pvalid_in = 0;
    chk("simul_underrun", under, 1);
    chk("simul_pready", pif.pready_out, 0);
    repeat (2 * FC) @(negedge clk);
    chk("simul_next_frame", last_rx, 16'h5AC3);
    // backpressure streaming of 100 random pairs
    base = rx_data_frames; sent = 0;
    pif.pvalid_in = 1; pif.pldata_in = W'($urandom); pif.prdata_in = W'($urandom);
    for (int i = 0; i < 120 * FC && sent < 100; i++) begin
      @(negedge clk);
      if (m_acc) begin
        sent++; pif.pldata_in = W'($urandom); pif.prdata_in = W'($urandom);
      end
    end
    chk("bp_sent", sent, 100);
    cnt = 0;
    for (int i = 0; i < 5 * FC; i++) begin
      @(negedge clk);
      if (pif.pready_out) cnt++;
      if (m_acc) begin
        sent++; pif.pldata_in = W'($urandom); pif.prdata_in = W'($urandom);
      end
    end
    chk("bp_ready_cycles", cnt, 5);
    pif.pvalid_in = 0;
    repeat (3 * FC) @(negedge clk);
    chk("loopback_count", rx_data_frames - base, sent);
    // reset mid-frame with hold full
    send(8'h11, 8'h22);
    send(8'h33, 8'h44);
    for (int i = 0; i < 2 * FC && !(cur_bit() == 5 && m_full); i++) @(negedge clk);
    chk("pre_rst_pready", pif.pready_out, 0);
    #2 rst = 1;
    #1;
    chk("mid_rst_sclk", sclk, 0); chk("mid_rst_lrck", lrck, 0); chk("mid_rst_sdata", sdata, 0);
    chk("mid_rst_underrun", under, 0); chk("mid_rst_pready", pif.pready_out, 1);
    @(negedge clk);
    rst = 0;
    seen = 0;
    for (int i = 0; i < DIV + 3 && !seen; i++) begin
      @(negedge clk);
      seen = under;
    end
    chk("post_rst_underrun", seen, 1);
    repeat (FC + 8) @(negedge clk);
    chk("post_rst_silent", last_rx, 16'h0000);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
